// File: rtl/adc_sample_reader_pkg.sv
// Shared types and sizing helpers for the ADC sample reader.
// Imported by the reader top and its sample FIFO.
package adc_rd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      SHIFT,
      TRAIL,
      GAP
   } state_t;

   localparam int DEF_DATA_W     = 12;
   localparam int DEF_CLK_DIV    = 4;
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int DEF_GAP_CYCLES = 2;

   function automatic int lvl_w(int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int cnt_w(int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/adc_sample_reader_if.sv
// ADC serial bus plus the sample stream toward the consumer.
// master = reader side, slave = ADC/consumer side.
interface adc_sample_reader_if #(
   parameter int DATA_W = 12
);
   logic              cs_n;
   logic              sclk;
   logic              miso;
   logic [DATA_W-1:0] smp_data;
   logic              smp_valid;
   logic              smp_ready;

   modport master (
      output cs_n, sclk, smp_data, smp_valid,
      input  miso, smp_ready
   );

   modport slave (
      input  cs_n, sclk, smp_data, smp_valid,
      output miso, smp_ready
   );
endinterface

// File: rtl/adc_sample_reader_fifo.sv
// First-word-fall-through sample buffer with occupancy count.
// A write into a full FIFO is only accepted when a pop frees the slot.
module sample_fifo
   import adc_rd_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            push,
   input  logic [DATA_W-1:0]               wdata,
   input  logic                            pop,
   output logic [DATA_W-1:0]               rdata,
   output logic                            full,
   output logic                            empty,
   output logic [lvl_w(FIFO_DEPTH)-1:0]    level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = lvl_w(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [LW-1:0]     count;
   logic              wr_en;
   logic              rd_en;

   assign full  = (count == LW'(FIFO_DEPTH));
   assign empty = (count == '0);
   assign level = count;
   assign rdata = mem[rd_ptr];
   assign rd_en = pop & ~empty;
   assign wr_en = push & (~full | rd_en);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         unique case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/adc_sample_reader.sv
// Serial ADC master: frames cs_n/sclk, shifts samples in MSB first
// and hands them to a FWFT FIFO feeding a valid/ready stream.
module adc_sample_reader
   import adc_rd_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         clr_ovf,
   adc_sample_reader_if.master          bus,
   output logic [lvl_w(FIFO_DEPTH)-1:0] level,
   output logic                         overflow
);

   localparam int MAXC = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
   localparam int CW   = cnt_w(MAXC);
   localparam int BW   = cnt_w(DATA_W);

   localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_END = CW'(GAP_CYCLES - 1);
   localparam logic [BW-1:0] BIT_END = BW'(DATA_W - 1);

   state_t            state;
   state_t            state_n;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_n;
   logic [BW-1:0]     bitc;
   logic [BW-1:0]     bitc_n;
   logic              hi;
   logic              hi_n;
   logic              sclk_q;
   logic              cs_n_q;
   logic              sclk_n;
   logic              cs_n_n;
   logic              rise;
   logic [DATA_W-1:0] sr;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic              drop;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bitc_n  = bitc;
      hi_n    = hi;
      unique case (state)
         IDLE: begin
            if (enable) begin
               state_n = LEAD;
               cnt_n   = '0;
            end
         end
         LEAD: begin
            if (cnt == DIV_END) begin
               state_n = SHIFT;
               cnt_n   = '0;
               hi_n    = 1'b1;
               bitc_n  = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         SHIFT: begin
            if (cnt == DIV_END) begin
               cnt_n = '0;
               if (hi) begin
                  hi_n = 1'b0;
               end else if (bitc == BIT_END) begin
                  state_n = TRAIL;
               end else begin
                  hi_n   = 1'b1;
                  bitc_n = bitc + 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         TRAIL: begin
            if (cnt == DIV_END) begin
               state_n = GAP;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         GAP: begin
            if (cnt == GAP_END) begin
               state_n = enable ? LEAD : IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Pins are registered from the next state so they track the FSM exactly.
   assign sclk_n = (state_n == SHIFT) & hi_n;
   assign cs_n_n = (state_n == IDLE) | (state_n == GAP);
   assign rise   = sclk_n & ~sclk_q;

   assign push = (state == TRAIL) & (cnt == '0);
   assign pop  = bus.smp_valid & bus.smp_ready;
   assign drop = push & full & ~pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bitc     <= '0;
         hi       <= 1'b0;
         sclk_q   <= 1'b0;
         cs_n_q   <= 1'b1;
         sr       <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         bitc     <= bitc_n;
         hi       <= hi_n;
         sclk_q   <= sclk_n;
         cs_n_q   <= cs_n_n;
         overflow <= drop | (overflow & ~clr_ovf);
         if (rise) sr <= {sr[DATA_W-2:0], bus.miso};
      end
   end

   assign bus.sclk      = sclk_q;
   assign bus.cs_n      = cs_n_q;
   assign bus.smp_valid = ~empty;

   sample_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (sr),
      .pop   (pop),
      .rdata (bus.smp_data),
      .full  (full),
      .empty (empty),
      .level (level)
   );

endmodule

// File: tb/tb_adc_sample_reader.sv
// Scoreboard bench: an ADC model serves directed words, a monitor
// compares every accepted sample against the expected queue.
module tb_adc_sample_reader;
   import adc_rd_pkg::*;

   localparam int DW = 12;
   localparam int CD = 4;
   localparam int FD = 8;
   localparam int GC = 2;
   localparam int LOW_CYC  = 2 * CD * (DW + 1);
   localparam int PUSH_CYC = CD + 2 * CD * DW;
   localparam int VLAT     = PUSH_CYC + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       clr_ovf = 1'b0;
   logic [3:0] level;
   logic       overflow;

   int total = 0;
   int passed = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] adc_q[$];
   logic [DW-1:0] word = '0;
   int            bitn = DW - 1;
   logic          cs_seen = 1'b1;

   adc_sample_reader_if #(.DATA_W(DW)) bus();

   adc_sample_reader #(
      .DATA_W     (DW),
      .CLK_DIV    (CD),
      .FIFO_DEPTH (FD),
      .GAP_CYCLES (GC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .clr_ovf  (clr_ovf),
      .bus      (bus),
      .level    (level),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, int act, int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ADC model: new word on cs_n fall, next bit after each sclk fall.
   always @(bus.cs_n or negedge bus.sclk) begin
      if (bus.cs_n != cs_seen) begin
         cs_seen = bus.cs_n;
         if (!bus.cs_n) begin
            word = (adc_q.size() > 0) ? adc_q.pop_front() : '0;
            bitn = DW - 1;
         end
      end else if (!bus.cs_n && bitn > 0) begin
         bitn--;
      end
      bus.miso = word[bitn];
   end

   always @(negedge clk) begin
      if (!rst && bus.smp_valid && bus.smp_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_sample: got %0h expected none",
                     bus.smp_data);
         end else begin
            chk("sample", int'(bus.smp_data), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic next_conv(output bit ok);
      int n = 0;
      while (bus.cs_n == 1'b0 && n < 2000) begin tick(); n++; end
      while (bus.cs_n == 1'b1 && n < 2000) begin tick(); n++; end
      ok = !bus.cs_n;
      if (!ok) begin
         total++;
         $display("FAIL conv_start: got timeout expected cs_n low");
      end
   endtask

   task automatic conv_watch(output int low, output int rises,
                             output int vlat);
      logic prev;
      low = 1; rises = 0; vlat = -1;
      prev = bus.sclk;
      for (int idx = 1; idx < 2000; idx++) begin
         tick();
         if (bus.cs_n) break;
         low++;
         if (bus.sclk && !prev) rises++;
         prev = bus.sclk;
         if (bus.smp_valid && vlat < 0) vlat = idx;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.cs_n == 1'b0 && n < 2000) begin tick(); n++; end
      repeat (4) tick();
   endtask

   task automatic drain();
      int n = 0;
      bus.smp_ready = 1'b1;
      while (exp_q.size() > 0 && n < 200) begin tick(); n++; end
      if (exp_q.size() > 0) begin
         total++;
         $display("FAIL drain: got %0d left expected 0", exp_q.size());
      end
      tick();
      tick();
      chk("drain_valid", int'(bus.smp_valid), 0);
      chk("drain_level", int'(level), 0);
   endtask

   task automatic idle_lows(input int cycles, output int lows);
      lows = 0;
      repeat (cycles) begin
         tick();
         if (!bus.cs_n) lows++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      int low, rises, vlat, lows, n;
      bus.miso = 1'b0;
      bus.smp_ready = 1'b0;
      repeat (3) tick();
      chk("rst_cs_n", int'(bus.cs_n), 1);
      chk("rst_sclk", int'(bus.sclk), 0);
      chk("rst_valid", int'(bus.smp_valid), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_ovf", int'(overflow), 0);
      rst = 1'b0;
      tick();

      // single conversion timing
      adc_q.push_back(12'hA5C);
      exp_q.push_back(12'hA5C);
      bus.smp_ready = 1'b1;
      enable = 1'b1;
      next_conv(ok);
      enable = 1'b0;
      if (ok) begin
         conv_watch(low, rises, vlat);
         chk("cs_low_cycles", low, LOW_CYC);
         chk("sclk_rises", rises, DW);
         chk("valid_latency", vlat, VLAT);
      end
      idle_lows(150, lows);
      chk("stays_idle", lows, 0);

      // overflow: ten samples into eight slots
      bus.smp_ready = 1'b0;
      for (int i = 1; i <= 10; i++) adc_q.push_back(DW'(i));
      for (int i = 1; i <= 8; i++) exp_q.push_back(DW'(i));
      enable = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         next_conv(ok);
         if (i == 10) enable = 1'b0;
      end
      wait_idle();
      chk("full_level", int'(level), 8);
      chk("full_ovf", int'(overflow), 1);
      drain();

      tick();
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("clr_alone", int'(overflow), 0);

      // full FIFO: push with pop, then drop with clear
      bus.smp_ready = 1'b0;
      for (int i = 1; i <= 10; i++) adc_q.push_back(DW'(12'h100 + i));
      for (int i = 1; i <= 9; i++) exp_q.push_back(DW'(12'h100 + i));
      enable = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         next_conv(ok);
         if (i == 9) begin
            repeat (PUSH_CYC) tick();
            bus.smp_ready = 1'b1;
            tick();
            bus.smp_ready = 1'b0;
            chk("pushpop_level", int'(level), 8);
            chk("pushpop_ovf", int'(overflow), 0);
         end
         if (i == 10) begin
            enable = 1'b0;
            repeat (PUSH_CYC) tick();
            clr_ovf = 1'b1;
            tick();
            clr_ovf = 1'b0;
            chk("clr_vs_drop", int'(overflow), 1);
            chk("drop_level", int'(level), 8);
         end
      end
      wait_idle();
      drain();

      // enable dropped mid-conversion
      bus.smp_ready = 1'b1;
      adc_q.push_back(12'h3C7);
      exp_q.push_back(12'h3C7);
      enable = 1'b1;
      next_conv(ok);
      rises = 0;
      n = 0;
      while (rises < 5 && n < 500) begin
         logic prev;
         prev = bus.sclk;
         tick();
         n++;
         if (bus.sclk && !prev) rises++;
      end
      enable = 1'b0;
      wait_idle();
      chk("fsm_idle", int'(dut.state), int'(IDLE));
      idle_lows(150, lows);
      chk("no_new_lead", lows, 0);
      chk("mid_drop_pushed", exp_q.size(), 0);

      // reset during SHIFT
      bus.smp_ready = 1'b0;
      adc_q.push_back(12'h7E1);
      adc_q.push_back(12'h111);
      adc_q.push_back(12'h5A3);
      enable = 1'b1;
      next_conv(ok);
      next_conv(ok);
      chk("pre_rst_level", int'(level), 1);
      repeat (30) tick();
      chk("pre_rst_shift", int'(dut.state), int'(SHIFT));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("post_rst_cs_n", int'(bus.cs_n), 1);
      chk("post_rst_sclk", int'(bus.sclk), 0);
      chk("post_rst_level", int'(level), 0);
      chk("post_rst_ovf", int'(overflow), 0);
      exp_q.push_back(12'h5A3);
      bus.smp_ready = 1'b1;
      next_conv(ok);
      enable = 1'b0;
      if (ok) begin
         conv_watch(low, rises, vlat);
         chk("fresh_low_cycles", low, LOW_CYC);
         chk("fresh_rises", rises, DW);
      end
      wait_idle();
      chk("all_samples_seen", exp_q.size(), 0);

      tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
